arb8_rr: RTL

- 8-requester round-robin arbiter that shares one downstream valid/ready channel, such as the memory or bus port behind the CPU's cache and uncached paths.
- Owns the 3-bit select of an 8:1 payload mux and holds a grant for a whole burst, until the requester's last beat handshakes.
- Sits between the requesters and a single bridge port, and sequences which source drives it.

---
 rtl/arb_pkg.sv | 15 +
 rtl/rr_pick8.sv | 41 ++++
 rtl/arb8_rr.sv | 135 +++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   ARB_N       number of requesters
//   ARB_IDX_W   width of a requester index
//   arb_state_t arbiter FSM states
package arb_pkg;

    localparam int ARB_N     = 8;
    localparam int ARB_IDX_W = 3;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick8.sv
// Round-robin pick for 8 requesters (purely combinational).
// The search starts just past ptr and wraps 7 -> 0.
// Ports:
//   req  in  [7:0]  request vector
//   ptr  in  [2:0]  index served last (lowest priority this round)
//   any  out        at least one request is set
//   idx  out [2:0]  winning index; only meaningful when any=1
module rr_pick8
    import arb_pkg::*;
(
    input  logic [ARB_N-1:0]     req,
    input  logic [ARB_IDX_W-1:0] ptr,
    output logic                 any,
    output logic [ARB_IDX_W-1:0] idx
);

    logic [3:0]           w_shift;
    logic [2*ARB_N-1:0]   w_dbl;
    logic [ARB_N-1:0]     w_rot;
    logic [ARB_IDX_W-1:0] w_off;

    // Rotate right by ptr+1 so that bit 0 is the highest-priority requester.
    // Doubling the vector turns the rotate into a plain shift; a shift of
    // 8 (ptr=7) leaves the original order.
    assign w_shift = {1'b0, ptr} + 4'd1;
    assign w_dbl   = {req, req} >> w_shift;
    assign w_rot   = w_dbl[ARB_N-1:0];

    // Lowest set bit of the rotated vector.
    always_comb begin
        w_off = '0;
        for (int i = ARB_N - 1; i >= 0; i--) begin
            if (w_rot[i]) w_off = ARB_IDX_W'(i);
        end
    end

    assign any = |req;
    // Undo the rotation; 3-bit arithmetic gives the mod-8 wrap.
    assign idx = w_off + ptr + 3'd1;

endmodule

// File: rtl/arb8_rr.sv
// 8-requester round-robin arbiter in front of one valid/ready channel.
// A grant is held for a whole burst and released after the granted
// requester's last beat handshakes; one IDLE bubble separates bursts.
// Optional macro ARB_TIMEOUT_EN: release a stalled grant after TIMEOUT
// consecutive cycles with the granted valid low and raise sticky timeout_err.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_valid     per-requester valid
//   req_last      per-requester last-beat flag
//   req_data      flattened payloads, requester i at [i*WIDTH +: WIDTH]
//   req_ready     per-requester ready, at most one bit set
//   out_valid/out_last/out_data/out_ready  downstream channel
//   out_sel       current grant index (payload mux select), held in IDLE
//   grant         one-hot grant, 0 when idle
//   busy          high while a grant is held
//   timeout_err   (ARB_TIMEOUT_EN only) sticky stall-timeout flag
module arb8_rr
    import arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ARB_N-1:0]       req_valid,
    input  logic [ARB_N-1:0]       req_last,
    input  logic [ARB_N*WIDTH-1:0] req_data,
    output logic [ARB_N-1:0]       req_ready,
    output logic                   out_valid,
    output logic                   out_last,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready,
    output logic [ARB_IDX_W-1:0]   out_sel,
    output logic [ARB_N-1:0]       grant,
`ifdef ARB_TIMEOUT_EN
    output logic                   busy,
    output logic                   timeout_err
`else
    output logic                   busy
`endif
);

    // Elaboration-time sanity check on the timeout length.
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("arb8_rr: TIMEOUT must be at least 1");
    end

    arb_state_t           r_state;
    logic [ARB_IDX_W-1:0] r_ptr;
    logic [ARB_IDX_W-1:0] r_sel;
    logic [ARB_N-1:0]     r_grant;

    logic                 w_any;
    logic [ARB_IDX_W-1:0] w_pick;
    logic                 w_end;

    rr_pick8 u_pick (
        .req (req_valid),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_pick)
    );

    assign busy    = (r_state == ARB_BUSY);
    assign out_sel = r_sel;
    assign grant   = r_grant;

    // Pass-through of the granted requester while BUSY.
    always_comb begin
        out_valid = busy & req_valid[r_sel];
        out_last  = busy & req_last[r_sel];
        out_data  = req_data[r_sel*WIDTH +: WIDTH];
        req_ready = '0;
        if (busy) req_ready[r_sel] = out_ready;
    end

    assign w_end = out_valid & out_ready & out_last;

`ifdef ARB_TIMEOUT_EN
    localparam int             CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_L = CNT_W'(TIMEOUT);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    assign w_cnt_inc = r_cnt + 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_ptr   <= 3'd7;
            r_sel   <= '0;
            r_grant <= '0;
`ifdef ARB_TIMEOUT_EN
            r_cnt       <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_any) begin
                        r_grant <= ARB_N'(1) << w_pick;
                        r_sel   <= w_pick;
                        r_state <= ARB_BUSY;
`ifdef ARB_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                ARB_BUSY: begin
                    if (w_end) begin
                        // Served requester becomes lowest priority next round.
                        r_state <= ARB_IDLE;
                        r_ptr   <= r_sel;
                        r_grant <= '0;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (req_valid[r_sel]) begin
                        r_cnt <= '0;
                    end else if (w_cnt_inc == TO_L) begin
                        r_state     <= ARB_IDLE;
                        r_ptr       <= r_sel;
                        r_grant     <= '0;
                        r_cnt       <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
`endif
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule
